uart_tx_serializer: RTL
=======================

UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 Parameter: DATA_WIDTH, 8, width of the parallel data word and the number of serial data bits per frame.
REQ-002 CLK  input  1  single clock for the block; one serial bit period per CLK cycle (bit-rate clock).
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 P_DATA  input  DATA_WIDTH  parallel byte to transmit; sampled only when a frame is accepted.
REQ-005 DATA_VALID  input  1  request to transmit P_DATA; level-sensitive, may stay high across frames.
REQ-006 PAR_EN  input  1  1 = insert parity bit after data; sampled with P_DATA.
REQ-007 PAR_TYP  input  1  0 = even parity, 1 = odd parity; sampled with P_DATA.
REQ-008 TX_OUT  output  1  serial line, idle high.
REQ-009 Busy  output  1  high for every cycle in which a frame bit is on TX_OUT.

Function
REQ-010 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-011 TX_OUT and Busy SHALL be registered, with no combinational path from any input.
REQ-012 IDLE: TX_OUT=1, Busy=0; at a rising edge with DATA_VALID=1, latch P_DATA, PAR_EN, PAR_TYP and go to START.
REQ-013 START: TX_OUT=0, Busy=1 for exactly 1 cycle, starting the cycle after the accepting edge (latency 1 cycle).
REQ-014 DATA: DATA_WIDTH cycles, LSB first, bit index counter 0..DATA_WIDTH-1; the counter SHALL clear on exit.
REQ-015 PARITY: entered only if latched PAR_EN=1; 1 cycle; bit = XOR of latched data (even) or its inverse (odd).
REQ-016 STOP: TX_OUT=1, Busy=1 for 1 cycle.
REQ-017 Frame length SHALL be 10 cycles with PAR_EN=0 and 11 cycles with PAR_EN=1 (DATA_WIDTH=8).
REQ-018 DATA_VALID in START/DATA/PARITY SHALL be ignored and not stored; changes to P_DATA, PAR_EN and PAR_TYP mid-frame SHALL NOT affect the current frame.
REQ-019 Back-to-back: if DATA_VALID=1 at the edge ending STOP, latch new inputs and go directly to START (no idle cycle, Busy stays 1).
REQ-020 If DATA_VALID=0 at the edge ending STOP, go to IDLE (TX_OUT=1, Busy=0).
REQ-021 Unreachable state encodings SHALL return to IDLE on the next edge.

Reset
REQ-022 RST=1 SHALL immediately force state IDLE, TX_OUT=1, Busy=0, bit counter=0, latched data/config=0, regardless of clock.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no partial bits after deassertion; the first edge after deassertion with DATA_VALID=1 starts a fresh frame.

Verification
REQ-024 P_DATA=0xA5, PAR_EN=0, 1-cycle DATA_VALID -> TX_OUT 0,1,0,1,0,0,1,0,1,1 then idle 1; Busy high 10 cycles.
REQ-025 P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 -> parity bit 0; PAR_TYP=1 -> parity bit 1; Busy high 11 cycles.
REQ-026 P_DATA=0x07, PAR_EN=1, PAR_TYP=0 -> parity 1; PAR_TYP=1 -> parity 0.
REQ-027 DATA_VALID held high, P_DATA changed to 0x3C during frame of 0x81 -> 0x81 frame intact, followed with no gap by a 0x3C frame; Busy continuously 1.
REQ-028 DATA_VALID pulsed in DATA state -> ignored; no second frame; Busy drops after STOP.
REQ-029 RST pulsed during DATA bit 3 -> TX_OUT=1, Busy=0 immediately; next DATA_VALID yields a full, correct frame.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// Bit-rate UART transmitter: one serial bit per clock, optional even/odd parity,
// back-to-back frames without an idle gap when a new request is waiting at stop.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [CNT_W-1:0]      bit_cnt;
    logic [CNT_W-1:0]      next_cnt;
    logic [DATA_WIDTH-1:0] data_lat;
    logic                  par_en_lat;
    logic                  par_typ_lat;
    logic                  accept;
    logic                  tx_next;
    logic                  busy_next;

    // A request is only honoured when the line is free or the current frame is on its stop bit.
    assign accept = DATA_VALID && ((state == IDLE) || (state == STOP));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            bit_cnt <= '0;
        end else begin
            state   <= next_state;
            bit_cnt <= next_cnt;
        end
    end

    always_comb begin
        next_state = IDLE;
        next_cnt   = '0;
        case (state)
            IDLE:   next_state = DATA_VALID ? START : IDLE;
            START:  next_state = DATA;
            DATA: begin
                if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                    next_state = par_en_lat ? PARITY : STOP;
                end else begin
                    next_state = DATA;
                    next_cnt   = bit_cnt + CNT_W'(1);
                end
            end
            PARITY: next_state = STOP;
            STOP:   next_state = DATA_VALID ? START : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are decoded from the state being entered so they can be registered with no lag.
    always_comb begin
        tx_next   = 1'b1;
        busy_next = 1'b1;
        case (next_state)
            IDLE:    busy_next = 1'b0;
            START:   tx_next   = 1'b0;
            DATA:    tx_next   = data_lat[next_cnt];
            PARITY:  tx_next   = (^data_lat) ^ par_typ_lat;
            STOP:    tx_next   = 1'b1;
            default: busy_next = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            TX_OUT <= 1'b1;
            Busy   <= 1'b0;
        end else begin
            TX_OUT <= tx_next;
            Busy   <= busy_next;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            data_lat    <= '0;
            par_en_lat  <= 1'b0;
            par_typ_lat <= 1'b0;
        end else if (accept) begin
            data_lat    <= P_DATA;
            par_en_lat  <= PAR_EN;
            par_typ_lat <= PAR_TYP;
        end
    end

endmodule
